// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave endpoint.
// Latency: none (declarations only); backpressure: not applicable.
package spi_pkg;
  localparam int   WORD_WIDTH = 8;
  localparam logic CS_IDLE    = 1'b1;
  localparam logic LSB_FIRST  = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one async pin plus rise/fall pulses from a trailing copy.
// Latency: SYNC_STAGES clk to sync_o, pulses valid in that same cycle; backpressure: none.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~dly_q;
  assign fall_o = ~sync_o & dly_q;
endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave, LSB first, oversampled in clk; rx word SYNC_STAGES+2 clk after the last sclk rise.
// Backpressure: one-entry tx buffer (tx_ready) and rx holding register (rx_valid); overflow only flags.
module spi_slave_port import spi_pkg::*; #(
  parameter int WIDTH       = WORD_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             rx_overrun,
  output logic             tx_underrun,
  output logic             frame_err
);
  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl_unused, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(sclk),
    .sync_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_cs_sync (
    .clk(clk), .reset(reset), .din(cs_n),
    .sync_o(cs_lvl_unused), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .din(mosi),
    .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] txbuf_q, txbuf_d;
  logic             txbuf_full_q, txbuf_full_d;
  logic             rx_overrun_q, rx_overrun_d;
  logic             tx_underrun_q, tx_underrun_d;
  logic             frame_err_q, frame_err_d;
  logic             und_pend_q, und_pend_d;
  logic             word_done, tx_load;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    txbuf_d       = txbuf_q;
    txbuf_full_d  = txbuf_full_q;
    rx_overrun_d  = rx_overrun_q;
    tx_underrun_d = tx_underrun_q;
    frame_err_d   = 1'b0;
    und_pend_d    = und_pend_q;
    tx_load       = 1'b0;
    word_done     = (state_q == ACTIVE) && (cnt_q == CNT_FULL);

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (word_done) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ready) rx_overrun_d = 1'b1;
      cnt_d      = '0;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          tx_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // A completed word in its hand-off cycle still counts; only a partial one is an error.
          state_d    = IDLE;
          frame_err_d = (cnt_q != '0) && !word_done;
          cnt_d      = '0;
          rx_shift_d = '0;
          und_pend_d = 1'b0;
        end else begin
          if (word_done) tx_load = 1'b1;
          if (sclk_rise) begin
            // An empty reload only counts as underrun once the master actually clocks that word.
            if (und_pend_q && (cnt_q == '0)) tx_underrun_d = 1'b1;
            und_pend_d = 1'b0;
            rx_shift_d = {mosi_s, rx_shift_q[WIDTH-1:1]};
            cnt_d      = cnt_d + CW'(1);
          end else if (sclk_fall && (cnt_q != '0) && !word_done) begin
            tx_shift_d = tx_shift_q >> 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_load) begin
      txbuf_full_d = 1'b0;
      tx_shift_d   = txbuf_full_q ? txbuf_q : '0;
      if (!txbuf_full_q) begin
        if (state_q == IDLE) tx_underrun_d = 1'b1;
        else                 und_pend_d    = 1'b1;
      end
    end

    if (tx_valid && !txbuf_full_q) begin
      txbuf_d      = tx_data;
      txbuf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      txbuf_q       <= '0;
      txbuf_full_q  <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
      und_pend_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      txbuf_q       <= txbuf_d;
      txbuf_full_q  <= txbuf_full_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
      und_pend_q    <= und_pend_d;
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign miso_oe     = busy;
  assign miso        = busy & tx_shift_q[0];
  assign tx_ready    = ~txbuf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: a mode-0 LSB-first master model with expected rx words and
// miso bits queued at stimulus time and popped by independent monitors.
module tb_spi_slave_port;
  import spi_pkg::*;

  localparam int W    = WORD_WIDTH;
  localparam int HALF = 50;

  logic         clk = 1'b0;
  logic         reset, sclk, cs_n, mosi, miso, miso_oe;
  logic [W-1:0] tx_data, rx_data;
  logic         tx_valid, tx_ready, rx_valid, rx_ready;
  logic         busy, rx_overrun, tx_underrun, frame_err;

  int n_pass  = 0;
  int n_total = 0;
  int fe_count = 0;
  int fe_before;

  logic [W-1:0] rx_exp[$];
  logic         miso_exp[$];

  always #5 clk = ~clk;

  spi_slave_port #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
    .frame_err(frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // rx scoreboard: every accepted word must match the next expected one.
  always @(negedge clk) begin
    if (!reset && frame_err) fe_count++;
    if (!reset && rx_valid && rx_ready) begin
      if (rx_exp.size() == 0) begin
        n_total++;
        $display("FAIL rx_unexpected: got word 0x%0h, none expected", rx_data);
      end else begin
        chk("rx_data", rx_data, rx_exp.pop_front());
      end
    end
  end

  // miso scoreboard: the master samples miso on each rising sclk.
  always @(posedge sclk) begin
    if (!cs_n && !reset) begin
      if (miso_exp.size() == 0) begin
        n_total++;
        $display("FAIL miso_unexpected: got bit %0b, none expected", miso);
      end else begin
        chk("miso_bit", miso, miso_exp.pop_front());
      end
    end
  end

  task automatic push_miso(input logic [W-1:0] d, input int n);
    for (int i = 0; i < n; i++) miso_exp.push_back(d[i]);
  endtask

  task automatic tx_write(input logic [W-1:0] d);
    bit done;
    done     = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        done = 1'b1;
        @(posedge clk);
        #2;
      end
    end
    tx_valid = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL tx_write_timeout: tx_ready stayed 0, needed 1 within 50 cycles");
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #60;
  endtask

  task automatic cs_high();
    #100;
    cs_n = 1'b1;
    #100;
  endtask

  task automatic send_bits(input logic [W-1:0] d, input int n, input bit lat);
    for (int i = 0; i < n; i++) begin
      mosi = d[i];
      #HALF;
      sclk = 1'b1;
      if (lat && i == n - 1) begin
        repeat (3) @(posedge clk);
        #1;
        chk("lat_rx_valid_before_s_plus_2", rx_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_rx_valid_at_s_plus_2", rx_valid, 1);
        #11;
      end else begin
        #HALF;
      end
      sclk = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", {tx_ready, rx_valid, miso, miso_oe, busy, rx_overrun, tx_underrun, frame_err}, 8'b1000_0000);
    chk("reset_rx_data", rx_data, 0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    // Single word.
    tx_write(8'h7F);
    push_miso(8'h7F, 8);
    rx_exp.push_back(8'h53);
    cs_low();
    chk("single_busy_oe", {busy, miso_oe}, 2'b11);
    chk("single_tx_ready_after_load", tx_ready, 1);
    send_bits(8'h53, 8, 1'b0);
    cs_high();
    chk("single_flags", {frame_err, tx_underrun, rx_overrun}, 3'b000);
    chk("single_fe_count", fe_count, 0);
    chk("single_idle", {busy, miso_oe, miso, rx_valid}, 4'b0000);
    chk("single_rx_drained", rx_exp.size(), 0);

    // Back-to-back words in one select, buffer refilled during the first.
    tx_write(8'h83);
    push_miso(8'h83, 8);
    push_miso(8'h98, 8);
    rx_exp.push_back(8'h22);
    rx_exp.push_back(8'h3C);
    cs_low();
    tx_write(8'h98);
    send_bits(8'h22, 8, 1'b0);
    send_bits(8'h3C, 8, 1'b0);
    cs_high();
    chk("b2b_underrun", tx_underrun, 0);
    chk("b2b_rx_drained", rx_exp.size(), 0);

    // Underrun and overrun.
    rx_ready = 1'b0;
    push_miso(8'h00, 8);
    push_miso(8'h00, 8);
    cs_low();
    chk("uo_underrun_at_start", tx_underrun, 1);
    send_bits(8'h25, 8, 1'b0);
    send_bits(8'hC2, 8, 1'b0);
    cs_high();
    chk("uo_rx_valid", rx_valid, 1);
    chk("uo_rx_data", rx_data, 8'hC2);
    chk("uo_overrun", rx_overrun, 1);
    rx_exp.push_back(8'hC2);
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("uo_rx_valid_dropped", rx_valid, 0);
    chk("uo_rx_drained", rx_exp.size(), 0);

    // Abort after 5 bits, then a clean word.
    fe_before = fe_count;
    push_miso(8'h00, 5);
    cs_low();
    send_bits(8'h1B, 5, 1'b0);
    cs_high();
    chk("abort_frame_err_pulses", fe_count - fe_before, 1);
    chk("abort_rx_valid_busy", {rx_valid, busy}, 2'b00);
    tx_write(8'h3C);
    push_miso(8'h3C, 8);
    rx_exp.push_back(8'hA5);
    cs_low();
    send_bits(8'hA5, 8, 1'b0);
    cs_high();
    chk("abort_next_rx_drained", rx_exp.size(), 0);

    // Reset in the middle of a word.
    tx_write(8'h0F);
    push_miso(8'h0F, 3);
    cs_low();
    send_bits(8'h5A, 3, 1'b0);
    fe_before = fe_count;
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {tx_ready, rx_valid, miso, miso_oe, busy, rx_overrun, tx_underrun, frame_err}, 8'b1000_0000);
    chk("midreset_rx_data", rx_data, 0);
    cs_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    tx_write(8'h96);
    push_miso(8'h96, 8);
    rx_exp.push_back(8'h5A);
    cs_low();
    send_bits(8'h5A, 8, 1'b1);
    cs_high();
    chk("midreset_no_frame_err", fe_count - fe_before, 0);
    chk("midreset_flags", {tx_underrun, rx_overrun}, 2'b00);
    chk("final_rx_drained", rx_exp.size(), 0);
    chk("final_miso_drained", miso_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    n_total++;
    $display("FAIL watchdog: simulation time reached 200 us, expected completion well before");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI slave endpoint sitting directly downstream of the SPI Master; one instance per chip-select line (CS[k]).
- Deserialises the master's MDO stream into parallel words and serialises a locally supplied word back onto the master's MDI.
- Runs entirely in the system clock domain, oversampling SCLK/CS; exposes valid/ready parallel handshakes to local logic.

Parameters:
- WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, synchroniser depth on sclk, cs_n, mosi (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x SCLK frequency.
- reset  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from master.
- cs_n  in  1  active-low select (one bit of master CS).
- mosi  in  1  serial data from master (master MDO).
- miso  out  1  serial data to master (master MDI).
- miso_oe  out  1  high while selected.
- tx_data  in  WIDTH  next word to return to master.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  one-entry tx buffer empty.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data.
- busy  out  1  state is ACTIVE.
- rx_overrun  out  1  sticky: word completed while rx_valid was still high.
- tx_underrun  out  1  sticky: word started with an empty tx buffer.
- frame_err  out  1  one-cycle pulse: cs_n deasserted mid-word.

Behaviour:
- Reset (async): all outputs 0 except tx_ready=1. Shift registers and bit counter cleared. State IDLE. Synchronisers preset to sclk=0, cs_n=1.
- Input path: sclk, cs_n, mosi each pass through SYNC_STAGES flops. A third registered copy of sclk/cs_n provides edge detection. Any pin edge is acted on SYNC_STAGES+1 clk cycles later.
- Bit order: LSB first. Bit 0 is the first bit on the wire in both directions, matching the master.
- SPI timing: mosi is sampled on rising sclk. miso is updated on falling sclk. The first miso bit is valid from word load.
- FSM IDLE -> ACTIVE on synchronised cs_n falling edge:
  - tx shifter is loaded from the tx buffer, and the buffer is freed (tx_ready=1 next cycle).
  - If the buffer is empty, 0 is loaded and tx_underrun is set.
  - Bit counter is set to 0.
  - miso = shifter bit 0; miso_oe = 1.
- In ACTIVE, on rising sclk: rx shifter takes mosi into its MSB and shifts right; counter increments.
- When the counter reaches WIDTH:
  - rx_data is loaded.
  - rx_valid = 1 on the next cycle.
  - If rx_valid was already 1 without handshake in the same cycle, rx_overrun is set and rx_data is overwritten.
  - Counter wraps to 0 and the next tx word is reloaded from the buffer (same underrun rule). This supports back-to-back words within one select.
- In ACTIVE, on falling sclk with counter != 0: tx shifter shifts right; miso = new bit 0.
- ACTIVE -> IDLE on synchronised cs_n rising edge. miso_oe and miso go to 0 that cycle.
  - If the counter is nonzero, the partial word is discarded, frame_err pulses for 1 cycle, and rx_valid is unaffected.
- Simultaneous rising sclk and cs_n rising in the same cycle: the cs_n edge wins and the bit is discarded.
- rx handshake: the word transfers when rx_valid && rx_ready. rx_valid drops the next cycle unless a new word completes that same cycle, in which case it stays 1 with the new data and there is no overrun.
- tx handshake: a write occurs when tx_valid && tx_ready. tx_ready falls the next cycle.
  - A write in the same cycle as a buffer load goes into the buffer; the load uses the old contents (or underruns).
- Sticky flags clear only on reset.
- Reset mid-word: immediate return to reset state; no rx_valid and no frame_err.

Decomposition:
- Shared package spi_pkg:
  - WORD_WIDTH=8 constant.
  - Two-value state enum (IDLE, ACTIVE).
  - CS_IDLE=1 constant.
  - LSB_FIRST=1 constant; the master uses the same constant.
- One natural sub-module, spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs. Instantiated for sclk and cs_n; mosi uses the synchroniser only.

Test Plan:
- Single word: tx buffer 0x7F; master sends 0x53 under cs_n. Expect rx_data=0x53 with rx_valid for one handshake. miso bit sequence 1,1,1,1,1,1,1,0. frame_err=0, tx_underrun=0.
- Back-to-back: buffer 0x83, then refill with 0x98 during word 1; two words 0x22 and 0x3C in one cs_n window. Expect rx 0x22 then 0x3C. miso carries 0x83 then 0x98, LSB first.
- Underrun and overrun: no tx write and rx_ready=0; master sends 0x25 then 0xC2. Expect miso all 0, tx_underrun=1, rx_overrun=1, rx_data=0xC2.
- Abort: cs_n raised after 5 rising sclk edges. Expect one frame_err pulse, rx_valid stays 0, busy=0. A following full word 0xA5 is received correctly.
- Reset mid-word: assert reset after 3 bits. Expect all outputs at reset values immediately, tx_ready=1. The next frame with 0x5A is received correctly.
- Latency check: sclk rising edge to rx shifter update is exactly SYNC_STAGES+1 clk cycles; 8th edge to rx_valid is SYNC_STAGES+2 cycles.
